// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: control encodings and the ID/EX pipeline record shared by the decode/execute boundary.
package id_ex_stage_pkg;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;
    localparam logic [1:0] REGDST_K0 = 2'b11;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        irq;
        logic [1:0]  pcsrc;
        logic        regwrite;
        logic [1:0]  regdst;
        logic        memread;
        logic        memwrite;
        logic [1:0]  memtoreg;
        logic        alusrc1;
        logic        alusrc2;
        logic [1:0]  aluop;
    } id_ex_t;

    // A bubble is an all-zero record: invalid, no writes, sequential PC, i.e. a NOP.
    localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// hazard_load_use: combinational load-use detector, shared with the forwarding unit.
module hazard_load_use (
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       load_use_o
);

    // Conservative: rt is compared even when the ID instruction only writes it.
    assign load_use_o = ex_valid_i & ex_memread_i & (ex_rt_i != 5'd0) & id_valid_i &
                        ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush squashing
// and saturating debug counters for bubbles and flushes.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [31:0]      id_pc_plus4,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_shamt,
    input  logic [5:0]       id_funct,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    input  logic             id_irq,
    input  logic [1:0]       id_pcsrc,
    input  logic             id_regwrite,
    input  logic [1:0]       id_regdst,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic [1:0]       id_memtoreg,
    input  logic             id_alusrc1,
    input  logic             id_alusrc2,
    input  logic [1:0]       id_aluop,
    output logic             ex_valid,
    output logic [31:0]      ex_pc_plus4,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_shamt,
    output logic [5:0]       ex_funct,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm,
    output logic             ex_irq,
    output logic [1:0]       ex_pcsrc,
    output logic             ex_regwrite,
    output logic [1:0]       ex_regdst,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic [1:0]       ex_memtoreg,
    output logic             ex_alusrc1,
    output logic             ex_alusrc2,
    output logic [1:0]       ex_aluop,
    output logic             load_use,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    id_ex_t           id_s, ex_q, ex_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             bubble_ins;

    assign id_s = '{
        valid:    id_valid,
        pc_plus4: id_pc_plus4,
        rs:       id_rs,
        rt:       id_rt,
        rd:       id_rd,
        shamt:    id_shamt,
        funct:    id_funct,
        rs_data:  id_rs_data,
        rt_data:  id_rt_data,
        imm:      id_imm,
        irq:      id_irq,
        pcsrc:    id_pcsrc,
        regwrite: id_regwrite,
        regdst:   id_regdst,
        memread:  id_memread,
        memwrite: id_memwrite,
        memtoreg: id_memtoreg,
        alusrc1:  id_alusrc1,
        alusrc2:  id_alusrc2,
        aluop:    id_aluop
    };

    hazard_load_use u_hazard (
        .ex_valid_i   (ex_q.valid),
        .ex_memread_i (ex_q.memread),
        .ex_rt_i      (ex_q.rt),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .load_use_o   (load_use)
    );

    // Flush outranks hold, and hold masks load_use, so a bubble is only counted when it is loaded.
    assign bubble_ins = ~flush & ~hold & load_use;

    always_comb begin
        ex_d         = flush ? BUBBLE : hold ? ex_q : load_use ? BUBBLE : id_s;
        flush_cnt_d  = (flush & ~&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        bubble_cnt_d = (bubble_ins & ~&bubble_cnt_q) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q         <= BUBBLE;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc_plus4 = ex_q.pc_plus4;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_rd       = ex_q.rd;
    assign ex_shamt    = ex_q.shamt;
    assign ex_funct    = ex_q.funct;
    assign ex_rs_data  = ex_q.rs_data;
    assign ex_rt_data  = ex_q.rt_data;
    assign ex_imm      = ex_q.imm;
    assign ex_irq      = ex_q.irq;
    assign ex_pcsrc    = ex_q.pcsrc;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_regdst   = ex_q.regdst;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_alusrc1  = ex_q.alusrc1;
    assign ex_alusrc2  = ex_q.alusrc2;
    assign ex_aluop    = ex_q.aluop;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of the ID/EX register against a cycle-level
// reference model; a 4-bit-counter instance shares the stimulus to exercise saturation.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        irq;
        logic [1:0]  pcsrc;
        logic        regwrite;
        logic [1:0]  regdst;
        logic        memread;
        logic        memwrite;
        logic [1:0]  memtoreg;
        logic        alusrc1;
        logic        alusrc2;
        logic [1:0]  aluop;
    } fld_t;

    logic clk = 0, reset, hold, flush;
    fld_t id;
    wire fld_t exa, exb;
    wire logic lua, lub;
    wire logic [15:0] bca, fca;
    wire logic [3:0] bcb, fcb;

    fld_t        m_ex;
    int unsigned m_bub, m_fl;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id.valid), .id_pc_plus4(id.pc4), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
        .id_shamt(id.shamt), .id_funct(id.funct), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data),
        .id_imm(id.imm), .id_irq(id.irq), .id_pcsrc(id.pcsrc), .id_regwrite(id.regwrite),
        .id_regdst(id.regdst), .id_memread(id.memread), .id_memwrite(id.memwrite),
        .id_memtoreg(id.memtoreg), .id_alusrc1(id.alusrc1), .id_alusrc2(id.alusrc2), .id_aluop(id.aluop),
        .ex_valid(exa.valid), .ex_pc_plus4(exa.pc4), .ex_rs(exa.rs), .ex_rt(exa.rt), .ex_rd(exa.rd),
        .ex_shamt(exa.shamt), .ex_funct(exa.funct), .ex_rs_data(exa.rs_data), .ex_rt_data(exa.rt_data),
        .ex_imm(exa.imm), .ex_irq(exa.irq), .ex_pcsrc(exa.pcsrc), .ex_regwrite(exa.regwrite),
        .ex_regdst(exa.regdst), .ex_memread(exa.memread), .ex_memwrite(exa.memwrite),
        .ex_memtoreg(exa.memtoreg), .ex_alusrc1(exa.alusrc1), .ex_alusrc2(exa.alusrc2), .ex_aluop(exa.aluop),
        .load_use(lua), .bubble_cnt(bca), .flush_cnt(fca)
    );

    id_ex_stage #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id.valid), .id_pc_plus4(id.pc4), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
        .id_shamt(id.shamt), .id_funct(id.funct), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data),
        .id_imm(id.imm), .id_irq(id.irq), .id_pcsrc(id.pcsrc), .id_regwrite(id.regwrite),
        .id_regdst(id.regdst), .id_memread(id.memread), .id_memwrite(id.memwrite),
        .id_memtoreg(id.memtoreg), .id_alusrc1(id.alusrc1), .id_alusrc2(id.alusrc2), .id_aluop(id.aluop),
        .ex_valid(exb.valid), .ex_pc_plus4(exb.pc4), .ex_rs(exb.rs), .ex_rt(exb.rt), .ex_rd(exb.rd),
        .ex_shamt(exb.shamt), .ex_funct(exb.funct), .ex_rs_data(exb.rs_data), .ex_rt_data(exb.rt_data),
        .ex_imm(exb.imm), .ex_irq(exb.irq), .ex_pcsrc(exb.pcsrc), .ex_regwrite(exb.regwrite),
        .ex_regdst(exb.regdst), .ex_memread(exb.memread), .ex_memwrite(exb.memwrite),
        .ex_memtoreg(exb.memtoreg), .ex_alusrc1(exb.alusrc1), .ex_alusrc2(exb.alusrc2), .ex_aluop(exb.aluop),
        .load_use(lub), .bubble_cnt(bcb), .flush_cnt(fcb)
    );

    // Reference model: the hazard rule as written, and counters as plain unbounded integers clipped on compare.
    function automatic logic model_lu();
        return m_ex.valid && m_ex.memread && m_ex.rt != 0 && id.valid &&
               (m_ex.rt == id.rs || m_ex.rt == id.rt);
    endfunction

    function automatic logic [15:0] sat16(int unsigned v);
        return (v > 65535) ? 16'hffff : v[15:0];
    endfunction

    function automatic logic [3:0] sat4(int unsigned v);
        return (v > 15) ? 4'hf : v[3:0];
    endfunction

    task automatic tick();
        logic lu;
        lu = model_lu();
        @(posedge clk);
        if (flush) begin
            m_ex = '0;
            m_fl++;
        end else if (!hold) begin
            if (lu) begin
                m_ex = '0;
                m_bub++;
            end else m_ex = id;
        end
        #1;
    endtask

    task automatic rand_id(input int reg_range);
        id = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        id.rs = 5'($urandom_range(reg_range));
        id.rt = 5'($urandom_range(reg_range));
        id.valid = ($urandom_range(7) != 0);
    endtask

    task automatic set_instr(input logic mr, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        rand_id(31);
        id.valid = 1;
        id.memread = mr;
        id.memwrite = 0;
        id.regwrite = 1;
        id.irq = 0;
        id.rs = rs;
        id.rt = rt;
        id.rd = rd;
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1 reset = 0;
        m_ex = '0;
        m_bub = 0;
        m_fl = 0;
    endtask

    task automatic test_reset();
        reset = 1; hold = 0; flush = 0; id = '0;
        m_ex = '0; m_bub = 0; m_fl = 0;
        #12;
        total++;
        if (exa !== '0 || exb !== '0) $display("FAIL reset_ex: a=%h b=%h want 0", exa, exb);
        else passed++;
        total++;
        if (bca !== 0 || fca !== 0 || bcb !== 0 || fcb !== 0)
            $display("FAIL reset_cnt: bub=%0d fl=%0d want 0", bca, fca);
        else passed++;
        reset = 0;
        // T1: async reset between edges after some traffic
        for (int i = 0; i < 20; i++) begin
            rand_id(3);
            flush = ($urandom_range(5) == 0);
            tick();
        end
        flush = 0;
        #3 reset = 1;
        #1;
        total++;
        if (exa !== '0 || bca !== 0 || fca !== 0 || lua !== 0)
            $display("FAIL midreset: ex=%h bub=%0d fl=%0d lu=%b want all 0", exa, bca, fca, lua);
        else passed++;
        m_ex = '0; m_bub = 0; m_fl = 0;
        #1 reset = 0;
    endtask

    task automatic test_load_use();
        set_instr(1, 9, 8, 0);
        tick();
        set_instr(0, 8, 11, 10);
        #1;
        total++;
        if (lua !== 1 || lua !== model_lu()) $display("FAIL lu_detect: got %b want 1", lua);
        else passed++;
        tick();
        total++;
        if (exa.valid !== 0 || exa.regwrite !== 0 || exa !== m_ex)
            $display("FAIL lu_bubble: ex=%h want %h", exa, m_ex);
        else passed++;
        total++;
        if (lua !== 0 || bca !== 16'(m_bub) || m_bub != 1) $display("FAIL lu_count: lu=%b bub=%0d want 0/1", lua, bca);
        else passed++;
        tick();
        total++;
        if (exa !== id || exa.rs !== 8 || exa.rd !== 10) $display("FAIL lu_add: ex=%h want %h", exa, id);
        else passed++;
    endtask

    task automatic test_zero_reg();
        set_instr(1, 4, 0, 0);
        tick();
        set_instr(0, 0, 0, 3);
        #1;
        total++;
        if (lua !== 0) $display("FAIL zero_lu: got %b want 0", lua);
        else passed++;
        tick();
        total++;
        if (exa !== id || bca !== 16'(m_bub)) $display("FAIL zero_pass: ex=%h want %h", exa, id);
        else passed++;
    endtask

    task automatic test_hold();
        fld_t held;
        int unsigned b0;
        set_instr(0, 2, 3, 4);
        id.funct = 6'h22;
        tick();
        held = id;
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id(31);
            tick();
            total++;
            if (exa !== held || exa !== m_ex) $display("FAIL hold_keep%0d: ex=%h want %h", i, exa, held);
            else passed++;
        end
        hold = 0;
        set_instr(1, 1, 6, 0);
        tick();
        b0 = m_bub;
        hold = 1;
        set_instr(0, 6, 2, 7);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (lua !== 1) $display("FAIL hold_lu%0d: got %b want 1", i, lua);
            else passed++;
            tick();
        end
        total++;
        if (bca !== 16'(b0) || exa.rt !== 6 || exa.memread !== 1)
            $display("FAIL hold_nobubble: bub=%0d rt=%0d want %0d/6", bca, exa.rt, b0);
        else passed++;
        hold = 0;
        tick();
        tick();
        total++;
        if (exa !== id || bca !== 16'(b0 + 1)) $display("FAIL hold_release: ex=%h bub=%0d want %h/%0d", exa, bca, id, b0 + 1);
        else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        set_instr(1, 1, 7, 0);
        tick();
        set_instr(0, 7, 7, 9);
        hold = 1;
        flush = 1;
        #1;
        total++;
        if (lua !== 1) $display("FAIL flush_lu: got %b want 1", lua);
        else passed++;
        tick();
        total++;
        if (exa !== '0 || fca !== 1 || bca !== 0 || fcb !== 1)
            $display("FAIL flush_prio: ex=%h fl=%0d bub=%0d want 0/1/0", exa, fca, bca);
        else passed++;
        hold = 0;
        flush = 0;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_instr(1, 3, 5, 0);
            tick();
            set_instr(0, 5, 1, 2);
            tick();
        end
        total++;
        if (bcb !== 4'hf || bca !== 16'd20 || bcb !== sat4(m_bub))
            $display("FAIL saturate: b4=%0d b16=%0d want 15/20", bcb, bca);
        else passed++;
        set_instr(0, 1, 2, 3);
        id.irq = 1;
        id.regdst = 2'b11;
        id.memtoreg = 2'b10;
        tick();
        total++;
        if (exb.irq !== 1 || exb.regdst !== 2'b11 || exb !== id || exa !== id)
            $display("FAIL irq_latch: irq=%b regdst=%b want 1/11", exb.irq, exb.regdst);
        else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            rand_id(3);
            hold = ($urandom_range(7) == 0);
            flush = ($urandom_range(9) == 0);
            #1;
            total++;
            if (lua !== model_lu() || lub !== lua) begin
                if (errs++ < 10) $display("FAIL rand_lu%0d: got %b want %b", i, lua, model_lu());
            end else passed++;
            tick();
            total++;
            if (exa !== m_ex || exb !== m_ex || bca !== sat16(m_bub) || fca !== sat16(m_fl) ||
                bcb !== sat4(m_bub) || fcb !== sat4(m_fl)) begin
                if (errs++ < 10)
                    $display("FAIL rand_state%0d: ex=%h bub=%0d fl=%0d want %h/%0d/%0d",
                             i, exa, bca, fca, m_ex, m_bub, m_fl);
            end else passed++;
        end
        hold = 0;
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_hold();
        test_flush();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
